// File: rtl/mips_rtype_pkg.sv
// rtl/mips_rtype_pkg.sv - opcode/funct codes, FSM states and ALU-op type for mips_rtype_mc
// Optional macro: MIPS_VSHIFT_EN enables the variable-shift functs (sllv/srlv/srav).
package mips_rtype_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'h00;

   typedef logic [5:0] alu_op_t;

   localparam alu_op_t FUNCT_SLL  = 6'h00;
   localparam alu_op_t FUNCT_SRL  = 6'h02;
   localparam alu_op_t FUNCT_SRA  = 6'h03;
   localparam alu_op_t FUNCT_SLLV = 6'h04;
   localparam alu_op_t FUNCT_SRLV = 6'h06;
   localparam alu_op_t FUNCT_SRAV = 6'h07;
   localparam alu_op_t FUNCT_ADD  = 6'h20;
   localparam alu_op_t FUNCT_ADDU = 6'h21;
   localparam alu_op_t FUNCT_SUB  = 6'h22;
   localparam alu_op_t FUNCT_SUBU = 6'h23;
   localparam alu_op_t FUNCT_AND  = 6'h24;
   localparam alu_op_t FUNCT_OR   = 6'h25;
   localparam alu_op_t FUNCT_XOR  = 6'h26;
   localparam alu_op_t FUNCT_NOR  = 6'h27;
   localparam alu_op_t FUNCT_SLT  = 6'h2A;
   localparam alu_op_t FUNCT_SLTU = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [5:0] instr_opcode(input logic [31:0] i);
      return i[31:26];
   endfunction

   function automatic alu_op_t instr_funct(input logic [31:0] i);
      return i[5:0];
   endfunction

endpackage

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - combinational R-type ALU (arith, logic, compare, shifts)
// Ports: a (rs value), b (rt value), shamt (instr[10:6]), funct
//        -> result, ovf (signed add/sub overflow), illegal (unsupported funct)
// Optional macro: MIPS_VSHIFT_EN accepts sllv/srlv/srav (amount = a[5:0]).
module mips_alu
   import mips_rtype_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [4:0]        shamt,
   input  alu_op_t           funct,
   output logic [DATA_W-1:0] result,
   output logic              ovf,
   output logic              illegal
);

   localparam logic [6:0] DW = 7'(DATA_W);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic [5:0]        sa;
   logic              sa_over;
   logic [DATA_W-1:0] shl_res;
   logic [DATA_W-1:0] shr_res;
   logic [DATA_W-1:0] sra_res;

   assign sum  = a + b;
   assign diff = a - b;

   // funct[2] separates the variable shifts from the immediate ones
   assign sa      = funct[2] ? a[5:0] : {1'b0, shamt};
   assign sa_over = {1'b0, sa} >= DW;

   always_comb begin
      shl_res = '0;
      shr_res = '0;
      sra_res = {DATA_W{b[DATA_W-1]}};
      if (!sa_over) begin
         shl_res = b << sa;
         shr_res = b >> sa;
         sra_res = $signed(b) >>> sa;
      end
   end

   always_comb begin
      result  = '0;
      ovf     = 1'b0;
      illegal = 1'b0;
      case (funct)
         FUNCT_ADD: begin
            result = sum;
            ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
         end
         FUNCT_ADDU: result = sum;
         FUNCT_SUB: begin
            result = diff;
            ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
         end
         FUNCT_SUBU: result = diff;
         FUNCT_AND:  result = a & b;
         FUNCT_OR:   result = a | b;
         FUNCT_XOR:  result = a ^ b;
         FUNCT_NOR:  result = ~(a | b);
         FUNCT_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
         FUNCT_SLTU: result = {{(DATA_W-1){1'b0}}, a < b};
         FUNCT_SLL:  result = shl_res;
         FUNCT_SRL:  result = shr_res;
         FUNCT_SRA:  result = sra_res;
`ifdef MIPS_VSHIFT_EN
         FUNCT_SLLV: result = shl_res;
         FUNCT_SRLV: result = shr_res;
         FUNCT_SRAV: result = sra_res;
`endif
         default:    illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_rtype_mc.sv
// rtl/mips_rtype_mc.sv - multi-cycle MIPS R-type execution unit with register file
// Ports: clk, rst_n (async, active low)
//        instr_valid/instr_ready/instr      : instruction channel
//        result_valid/result_ready          : result channel
//        result, wr_addr (rd), wr_en (committed), ovf, illegal
// Optional macro: MIPS_VSHIFT_EN (variable shifts, handled inside mips_alu).
module mips_rtype_mc
   import mips_rtype_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [DATA_W-1:0] result,
   output logic [4:0]        wr_addr,
   output logic              wr_en,
   output logic              ovf,
   output logic              illegal
);

   state_t            state;
   logic [31:0]       ir;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] regs [REG_N];

   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;

   logic [DATA_W-1:0] alu_res;
   logic              alu_ovf;
   logic              alu_ill;
   logic              ex_ill;
   logic              ex_ovf;
   logic [DATA_W-1:0] ex_res;
   logic              commit;

   function automatic logic in_range(input logic [4:0] idx);
      return {27'b0, idx} < REG_N;
   endfunction

   assign rs = ir[25:21];
   assign rt = ir[20:16];
   assign rd = ir[15:11];

   // Indices past the implemented register count read as zero
   assign rs_val = in_range(rs) ? regs[rs] : '0;
   assign rt_val = in_range(rt) ? regs[rt] : '0;

   mips_alu #(.DATA_W(DATA_W)) u_alu (
      .a       (op_a),
      .b       (op_b),
      .shamt   (ir[10:6]),
      .funct   (instr_funct(ir)),
      .result  (alu_res),
      .ovf     (alu_ovf),
      .illegal (alu_ill)
   );

   // A non-R-type opcode overrides whatever the ALU made of the funct field
   assign ex_ill = (instr_opcode(ir) != OPC_RTYPE) || alu_ill;
   assign ex_ovf = !ex_ill && alu_ovf;
   assign ex_res = ex_ill ? '0 : alu_res;
   assign commit = !ex_ill && !ex_ovf && (rd != 5'd0) && in_range(rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ir           <= '0;
         op_a         <= '0;
         op_b         <= '0;
         instr_ready  <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         wr_addr      <= '0;
         wr_en        <= 1'b0;
         ovf          <= 1'b0;
         illegal      <= 1'b0;
         for (int i = 0; i < REG_N; i++) regs[i] <= DATA_W'(i);
      end else begin
         case (state)
            IDLE: begin
               if (instr_ready && instr_valid) begin
                  ir          <= instr;
                  instr_ready <= 1'b0;
                  state       <= READ;
               end else begin
                  instr_ready <= 1'b1;
               end
            end
            READ: begin
               op_a  <= rs_val;
               op_b  <= rt_val;
               state <= EXEC;
            end
            EXEC: begin
               result       <= ex_res;
               ovf          <= ex_ovf;
               illegal      <= ex_ill;
               wr_addr      <= rd;
               wr_en        <= commit;
               result_valid <= 1'b1;
               // Writing here lets the next instruction read the new value without a bypass
               if (commit) regs[rd] <= ex_res;
               state        <= DONE;
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  instr_ready  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_rtype_mc.sv
// tb/tb_mips_rtype_mc.sv - self-checking bench for mips_rtype_mc
module tb_mips_rtype_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0;
   logic        result_valid;
   logic        result_ready = 1'b1;
   logic [31:0] result;
   logic [4:0]  wr_addr;
   logic        wr_en;
   logic        ovf;
   logic        illegal;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  wa;
      logic        we;
      logic        ov;
      logic        il;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] mreg [32];

   logic [31:0] o_res;
   logic [4:0]  o_wa;
   logic        o_we, o_ov, o_il;
   int          o_lat, o_acc;
   logic        o_ok;

   mips_rtype_mc #(.DATA_W(32), .REG_N(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result),
      .wr_addr      (wr_addr),
      .wr_en        (wr_en),
      .ovf          (ovf),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   task automatic preload();
      for (int i = 0; i < 32; i++) mreg[i] = 32'(i);
   endtask

   // Reference model: 33-bit sign-extended arithmetic for overflow, shifts by integer amount
   task automatic model(input logic [31:0] ins, output exp_t e);
      logic [31:0] a, b, r;
      logic [32:0] w;
      logic        ov, il;
      int          sa;
      a = mreg[ins[25:21]];
      b = mreg[ins[20:16]];
      r = '0; ov = 1'b0; il = 1'b0;
      sa = int'(ins[10:6]);
      if (ins[31:26] != 6'd0) il = 1'b1;
      else begin
         case (ins[5:0])
            6'h20: begin w = {a[31], a} + {b[31], b}; r = w[31:0]; ov = w[32] ^ w[31]; end
            6'h21: r = a + b;
            6'h22: begin w = {a[31], a} - {b[31], b}; r = w[31:0]; ov = w[32] ^ w[31]; end
            6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: r = (a < b) ? 32'd1 : 32'd0;
            6'h00: r = (sa >= 32) ? 32'd0 : (b << sa);
            6'h02: r = (sa >= 32) ? 32'd0 : (b >> sa);
            6'h03: r = (sa >= 32) ? {32{b[31]}} : 32'($signed(b) >>> sa);
`ifdef MIPS_VSHIFT_EN
            6'h04: begin sa = int'(a[5:0]); r = (sa >= 32) ? 32'd0 : (b << sa); end
            6'h06: begin sa = int'(a[5:0]); r = (sa >= 32) ? 32'd0 : (b >> sa); end
            6'h07: begin sa = int'(a[5:0]); r = (sa >= 32) ? {32{b[31]}} : 32'($signed(b) >>> sa); end
`endif
            default: il = 1'b1;
         endcase
      end
      if (il) begin r = '0; ov = 1'b0; end
      e.res = r;
      e.wa  = ins[15:11];
      e.ov  = ov;
      e.il  = il;
      e.we  = !il && !ov && (ins[15:11] != 5'd0);
      if (e.we) mreg[ins[15:11]] = r;
   endtask

   // Scoreboard monitor: one pop per completed result handshake
   always @(negedge clk) begin
      if (rst_n && result_valid && result_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got result=%h wr_addr=%0d with empty scoreboard", result, wr_addr);
         end else begin
            mon_e = sb.pop_front();
            if ({result, wr_addr, wr_en, ovf, illegal} !== mon_e) begin
               errors++;
               $display("FAIL sb_compare: got res=%h wa=%0d we=%b ovf=%b ill=%b, want res=%h wa=%0d we=%b ovf=%b ill=%b",
                        result, wr_addr, wr_en, ovf, illegal, mon_e.res, mon_e.wa, mon_e.we, mon_e.ov, mon_e.il);
            end
         end
      end
   end

   // Drive one instruction until accepted; leaves the unit in READ (#1 after accept edge)
   task automatic send(input logic [31:0] ins);
      int   n;
      exp_t e;
      instr = ins;
      instr_valid = 1'b1;
      n = 0;
      o_ok = 1'b1;
      @(negedge clk);
      while (!instr_ready && n < 20) begin n++; @(negedge clk); end
      if (!instr_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: instr=%h instr_ready=%b, required 1", ins, instr_ready);
         instr_valid = 1'b0;
         o_ok = 1'b0;
         return;
      end
      model(ins, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      o_acc = cyc;
      instr_valid = 1'b0;
   endtask

   task automatic exec(input logic [31:0] ins);
      int n;
      send(ins);
      if (!o_ok) return;
      o_lat = 1;
      n = 0;
      @(negedge clk);
      while (!result_valid && n < 20) begin @(posedge clk); o_lat++; n++; @(negedge clk); end
      if (!result_valid) begin
         checks++; errors++;
         $display("FAIL result_timeout: instr=%h result_valid=%b, required 1", ins, result_valid);
         o_ok = 1'b0;
         return;
      end
      o_res = result; o_wa = wr_addr; o_we = wr_en; o_ov = ovf; o_il = illegal;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({instr_ready, result_valid, result, wr_addr, wr_en, ovf, illegal} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h wa=%0d we=%b ovf=%b ill=%b, required all 0",
                  instr_ready, result_valid, result, wr_addr, wr_en, ovf, illegal);
      end
      preload();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add();
      exec(32'h0043_4820);
      checks++;
      if (o_res !== 32'd5 || o_wa !== 5'd9 || o_we !== 1'b1) begin
         errors++;
         $display("FAIL add_r9: got res=%h wa=%0d we=%b, required res=5 wa=9 we=1", o_res, o_wa, o_we);
      end
      checks++;
      if (o_lat !== 3) begin
         errors++;
         $display("FAIL add_latency: got %0d clocks, required 3", o_lat);
      end
   endtask

   task automatic test_arith();
      logic [31:0] tbl [5];
      exec(32'h0043_A022);
      checks++;
      if (o_res !== 32'hFFFF_FFFF || o_ov !== 1'b0) begin
         errors++;
         $display("FAIL sub_r20: got res=%h ovf=%b, required ffffffff ovf=0", o_res, o_ov);
      end
      exec(32'h0043_702A);
      checks++;
      if (o_res !== 32'd1) begin errors++; $display("FAIL slt_r14: got %h, required 1", o_res); end
      exec(32'h0062_782B);
      checks++;
      if (o_res !== 32'd0) begin errors++; $display("FAIL sltu_r15: got %h, required 0", o_res); end
      // remaining logic/compare functs against the scoreboard only
      tbl[0] = rtype(20, 31, 12, 0, 6'h24);
      tbl[1] = rtype(2, 29, 12, 0, 6'h25);
      tbl[2] = rtype(20, 7, 12, 0, 6'h26);
      tbl[3] = rtype(2, 3, 12, 0, 6'h27);
      tbl[4] = rtype(3, 20, 12, 0, 6'h23);
      for (int i = 0; i < 5; i++) exec(tbl[i]);
      exec(rtype(20, 2, 13, 0, 6'h2A));
      checks++;
      if (o_res !== 32'd1) begin errors++; $display("FAIL slt_neg: got %h, required 1", o_res); end
   endtask

   task automatic test_shift();
      exec(32'h001F_80C0);
      checks++;
      if (o_res !== 32'd248) begin errors++; $display("FAIL sll_r16: got %h, required f8", o_res); end
      exec(32'h001F_88C2);
      checks++;
      if (o_res !== 32'd3) begin errors++; $display("FAIL srl_r17: got %h, required 3", o_res); end
      exec(rtype(0, 1, 18, 31, 6'h00));
      checks++;
      if (o_res !== 32'h8000_0000) begin errors++; $display("FAIL sll_r18: got %h, required 80000000", o_res); end
      exec(rtype(0, 18, 19, 31, 6'h03));
      checks++;
      if (o_res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra_r19: got %h, required ffffffff", o_res); end
   endtask

   task automatic test_overflow();
      exec(rtype(0, 31, 5, 26, 6'h00));
      checks++;
      if (o_res !== 32'h7C00_0000) begin errors++; $display("FAIL sll_r5: got %h, required 7c000000", o_res); end
      exec(rtype(5, 5, 6, 0, 6'h20));
      checks++;
      if (o_res !== 32'hF800_0000 || o_ov !== 1'b1 || o_we !== 1'b0) begin
         errors++;
         $display("FAIL add_ovf: got res=%h ovf=%b we=%b, required f8000000 ovf=1 we=0", o_res, o_ov, o_we);
      end
      exec(rtype(6, 0, 7, 0, 6'h20));
      checks++;
      if (o_res !== 32'd6) begin errors++; $display("FAIL r6_unchanged: got %h, required 6", o_res); end
      exec(rtype(5, 5, 8, 0, 6'h21));
      checks++;
      if (o_res !== 32'hF800_0000 || o_ov !== 1'b0 || o_we !== 1'b1) begin
         errors++;
         $display("FAIL addu_noovf: got res=%h ovf=%b we=%b, required f8000000 ovf=0 we=1", o_res, o_ov, o_we);
      end
   endtask

   task automatic test_illegal();
      exec(32'h8C43_0000);
      checks++;
      if (o_il !== 1'b1 || o_res !== 32'd0 || o_we !== 1'b0) begin
         errors++;
         $display("FAIL illegal_opc: got ill=%b res=%h we=%b, required ill=1 res=0 we=0", o_il, o_res, o_we);
      end
      exec(rtype(2, 3, 12, 0, 6'h3F));
      checks++;
      if (o_il !== 1'b1 || o_we !== 1'b0) begin
         errors++;
         $display("FAIL illegal_funct: got ill=%b we=%b, required ill=1 we=0", o_il, o_we);
      end
      exec(rtype(2, 3, 12, 0, 6'h04));
      checks++;
`ifdef MIPS_VSHIFT_EN
      if (o_il !== 1'b0 || o_res !== 32'd12) begin
         errors++;
         $display("FAIL sllv: got ill=%b res=%h, required ill=0 res=c", o_il, o_res);
      end
      exec(rtype(20, 18, 13, 0, 6'h07));
      checks++;
      if (o_res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL srav_big: got %h, required ffffffff", o_res); end
      exec(rtype(20, 18, 13, 0, 6'h06));
      checks++;
      if (o_res !== 32'd0) begin errors++; $display("FAIL srlv_big: got %h, required 0", o_res); end
`else
      if (o_il !== 1'b1 || o_res !== 32'd0) begin
         errors++;
         $display("FAIL sllv_illegal: got ill=%b res=%h, required ill=1 res=0", o_il, o_res);
      end
`endif
   endtask

   task automatic test_r0();
      exec(rtype(2, 3, 0, 0, 6'h20));
      checks++;
      if (o_res !== 32'd5 || o_we !== 1'b0) begin
         errors++;
         $display("FAIL rd0_write: got res=%h we=%b, required res=5 we=0", o_res, o_we);
      end
      exec(rtype(0, 0, 10, 0, 6'h25));
      checks++;
      if (o_res !== 32'd0) begin errors++; $display("FAIL r0_read: got %h, required 0", o_res); end
   endtask

   task automatic test_back_to_back();
      int a0, a1;
      exec(rtype(2, 3, 21, 0, 6'h20));
      a0 = o_acc;
      exec(rtype(21, 21, 22, 0, 6'h20));
      a1 = o_acc;
      checks++;
      if (o_res !== 32'd10) begin errors++; $display("FAIL raw_r22: got %h, required a", o_res); end
      checks++;
      if (a1 - a0 !== 4) begin errors++; $display("FAIL throughput: got %0d clocks between accepts, required 4", a1 - a0); end
      exec(rtype(22, 21, 23, 0, 6'h20));
      checks++;
      if (o_res !== 32'd15) begin errors++; $display("FAIL raw_r23: got %h, required f", o_res); end
   endtask

   task automatic test_backpressure();
      logic [39:0] snap;
      int n;
      result_ready = 1'b0;
      send(rtype(2, 3, 24, 0, 6'h20));
      n = 0;
      @(negedge clk);
      while (!result_valid && n < 20) begin n++; @(negedge clk); end
      snap = {result, wr_addr, wr_en, ovf, illegal};
      checks++;
      if (result_valid !== 1'b1 || result !== 32'd5) begin
         errors++;
         $display("FAIL bp_result: got vld=%b res=%h, required vld=1 res=5", result_valid, result);
      end
      instr = rtype(2, 2, 25, 0, 6'h20);
      instr_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (result_valid !== 1'b1 || instr_ready !== 1'b0 || {result, wr_addr, wr_en, ovf, illegal} !== snap) begin
            errors++;
            $display("FAIL bp_stable[%0d]: got vld=%b rdy=%b out=%h, required vld=1 rdy=0 out=%h",
                     k, result_valid, instr_ready, {result, wr_addr, wr_en, ovf, illegal}, snap);
         end
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      exec(rtype(25, 0, 26, 0, 6'h25));
      checks++;
      if (o_res !== 32'd25) begin errors++; $display("FAIL bp_ignored: got r25=%h, required 19", o_res); end
   endtask

   task automatic test_reset_midop();
      send(rtype(2, 3, 9, 0, 6'h20));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({instr_ready, result_valid, result, wr_addr, wr_en, ovf, illegal} !== '0) begin
         errors++;
         $display("FAIL midop_reset: got rdy=%b vld=%b res=%h wa=%0d we=%b ovf=%b ill=%b, required all 0",
                  instr_ready, result_valid, result, wr_addr, wr_en, ovf, illegal);
      end
      if (sb.size() > 0) void'(sb.pop_back());
      preload();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exec(rtype(9, 0, 11, 0, 6'h25));
      checks++;
      if (o_res !== 32'd9) begin errors++; $display("FAIL r9_preload: got %h, required 9", o_res); end
      exec(rtype(5, 0, 11, 0, 6'h25));
      checks++;
      if (o_res !== 32'd5) begin errors++; $display("FAIL r5_preload: got %h, required 5", o_res); end
   endtask

   initial begin
      preload();
      test_reset();
      test_add();
      test_arith();
      test_shift();
      test_overflow();
      test_illegal();
      test_r0();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d outstanding entries, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_rtype_mc.md
Name: mips_rtype_mc

Overview:
Multi-cycle, parametrised MIPS R-type execution unit with an integrated register file. It replaces the single-cycle combinational datapath. Instructions are accepted over a valid/ready handshake, executed over a fixed 3-state sequence, and the result is presented on a valid/ready output channel. Signed-overflow trapping and illegal-instruction flags are added.

Parameters:
DATA_W, 32, datapath and register width; legal range 8..64.
REG_N, 32, number of architectural registers; legal range 2..32. Register index >= REG_N reads as 0 and is never written.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  unit can accept an instruction
instr  input  32  MIPS instruction word
result_valid  output  1  result/flags valid
result_ready  input  1  consumer accepts result
result  output  DATA_W  ALU result
wr_addr  output  5  destination register (rd)
wr_en  output  1  1 = result was committed to rd
ovf  output  1  signed overflow on add/sub; no commit
illegal  output  1  unsupported opcode/funct; no commit

Behaviour:
- Reset (async, rst_n=0): state=IDLE; instr_ready=0 during reset; result_valid, result, wr_addr, wr_en, ovf, illegal=0; register r[i]=i for all i (deterministic preload).
- FSM: IDLE -> READ -> EXEC -> DONE -> IDLE.
- IDLE: instr_ready=1. On instr_valid, latch instr and go to READ.
- READ: latch r[rs], r[rt] into operand registers.
- EXEC: compute through mips_alu and register result/flags. Write r[rd] at the end of this cycle when: legal, no ovf, rd!=0, and rd<REG_N. Then go to DONE.
- DONE: result_valid=1, outputs stable. When result_ready=1, go to IDLE.
- Latency: instr accept edge to first result_valid cycle = 3 clocks. Throughput = 1 instruction per 4 clocks when result_ready is held high.
- The write completes before the next IDLE, so back-to-back RAW dependencies need no bypass.
- Supported (opcode 000000): funct 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed), 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra.
- Shifts: shift r[rt] by shamt. If shamt >= DATA_W: result 0 for sll/srl; result is all copies of the sign bit for sra.
- slt/sltu: result is zero-extended 1 or 0.
- add/sub: ovf=1 on two's-complement overflow. result carries the wrapped value; wr_en=0. addu/subu never set ovf.
- Any other opcode or funct: illegal=1, result=0, wr_en=0.
- rd=0: result is computed and flags are reported; wr_en=0.
- instr_valid while not in IDLE: ignored (instr_ready=0).
- Reset mid-operation: the in-flight instruction is discarded and registers re-preload.

Optional Feature:
MIPS_VSHIFT_EN:
- Defined: adds funct 0x04 sllv, 0x06 srlv, 0x07 srav. The shift amount is r[rs][5:0]; the same >= DATA_W rules apply.
- Undefined: these functs report illegal=1.

Decomposition:
- Package mips_rtype_pkg holds:
  - OPC_RTYPE and all FUNCT_* localparams;
  - the state enum (IDLE/READ/EXEC/DONE);
  - the ALU-op typedef.
- Sub-module mips_alu: purely combinational, parametrised by DATA_W. Inputs: a, b, shamt, funct. Outputs: result, ovf, illegal.
- The FSM and register file stay in mips_rtype_mc.

Test Plan:
- Reset, then add r9=r2+r3 (0x00434820) -> result=5, wr_addr=9, wr_en=1, result_valid exactly 3 clocks after accept.
- sub r20=r2-r3 (0x0043A022) -> result=0xFFFFFFFF, ovf=0. slt r14 (0x0043702A) -> 1. sltu r15=r3<r2 (0x0062782B) -> 0.
- sll r16=r31<<3 (0x001F80C0) -> 248. srl r17=r31>>3 (0x001F88C2) -> 3. sra of 0x80000000 by 31 -> 0xFFFFFFFF.
- Overflow: sll r5=r31<<26 -> 0x7C000000. Then add r6=r5+r5 -> ovf=1, wr_en=0. Then add r7=r6+r0 -> 6, confirming r6 unchanged. addu of the same operands -> 0xF8000000, ovf=0.
- Illegal opcode 0x8C430000 -> illegal=1, result=0, wr_en=0. Write to rd=0 -> wr_en=0, and a subsequent read of r0 returns 0.
- Backpressure and reset: hold result_ready=0 for 5 cycles -> outputs stable, instr_ready=0, extra instr_valid ignored. Assert rst_n=0 during EXEC -> all outputs 0, r9 reads back 9.
